// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: reset sequencer on the controlling side of a PLL rst/locked pair.
// Pulses the PLL reset, waits for lock with a timeout and bounded retries, requires
// lock to stay stable before releasing the system reset, and re-runs on lock loss.
//
// Ports:
//   refclk      in   PLL reference clock, all logic on its rising edge
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   restart     in   single-cycle request to restart from PLL_RST
//   pll_rst     out  reset to the PLL, active high
//   sys_rst     out  downstream system reset, active high
//   ready       out  high only in RUN
//   fault       out  high only in FAULT
//   retry_count out  failed attempts in the current sequence
//   lock_lost   out  sticky flag: lock dropped while in RUN
module pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic       lock_lost
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned CNT_MAX = max2(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                         LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lock_lost_d;
  logic               pll_rst_d, sys_rst_d, ready_d, fault_d;
  logic               sync1, lk;

  // Two-flop synchroniser for the asynchronous lock indicator
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  // Next-state, counter and next-output decode
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_count;
    lock_lost_d = lock_lost;
    cnt_d       = cnt_q;
    pll_rst_d   = 1'b1;
    sys_rst_d   = 1'b1;
    ready_d     = 1'b0;
    fault_d     = 1'b0;

    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PULSE_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_count == RETRY_LAST) begin
            state_d = S_FAULT;
          end else begin
            retry_d = retry_count + RETRY_W'(1);
            state_d = S_PLL_RST;
          end
        end
      end
      S_STABLE: begin
        if (!lk)                     state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lk) begin
          lock_lost_d = 1'b1;
          state_d     = S_PLL_RST;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_PLL_RST;
    endcase

    if (state_d == S_RUN) retry_d = '0;

    // restart overrides every lock-driven decision, including the lock_lost flag
    if (restart) begin
      state_d     = S_PLL_RST;
      retry_d     = '0;
      lock_lost_d = lock_lost;
    end

    // Counter clears on every state entry (restart counts as a re-entry)
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == S_PLL_RST) || (state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  // State, counter and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst     <= pll_rst_d;
      sys_rst     <= sys_rst_d;
      ready       <= ready_d;
      fault       <= fault_d;
      retry_count <= retry_d;
      lock_lost   <= lock_lost_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: scoreboard bench for pll_reset_ctrl. Expected output vectors
// {pll_rst, sys_rst, ready, fault, retry_count, lock_lost} are queued against the
// edge number at which they must appear and compared on the following falling edge.
module tb_pll_reset_ctrl;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic       lock_lost;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .lock_lost  (lock_lost)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s @edge %0d: got %b, want %b", tag, cyc, obs[8:0], exp[8:0]);
    else
      n_pass++;
  endtask

  function automatic logic [8:0] ov(input bit pr, input bit sr, input bit rd, input bit ft,
                                    input int r, input bit ll);
    return {pr, sr, rd, ft, 4'(r), ll};
  endfunction

  // Insert keeping the queue ordered by edge number
  task automatic push(input int at, input string tag, input logic [8:0] v);
    exp_t e;
    int   i;
    e.at = at; e.tag = tag; e.v = v;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  // Compare every expectation due at the edge just passed
  always @(negedge refclk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, 32'({pll_rst, sys_rst, ready, fault, retry_count, lock_lost}), 32'(e.v));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() > 0 && k < 400) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Apply reset for one edge; b is the edge after which rst is released
  task automatic do_reset(output int b);
    rst = 1'b1; restart = 1'b0; pll_locked = 1'b0;
    push(cyc + 1, "reset_vals", ov(1, 1, 0, 0, 0, 0));
    tick(1);
    rst = 1'b0;
    b = cyc;
  endtask

  localparam logic [8:0] RST_V = 9'b1_1_0_0_0000_0;

  initial begin
    int b;
    int c;
    int d;
    rst = 1'b1; restart = 1'b0; pll_locked = 1'b0;
    tick(2);

    // 1. Nominal lock
    do_reset(b);
    push(b + 3,  "s1_pulse_end", ov(1, 1, 0, 0, 0, 0));
    push(b + 4,  "s1_wait_lock", ov(0, 1, 0, 0, 0, 0));
    push(b + 20, "s1_before_rel", ov(0, 1, 0, 0, 0, 0));
    push(b + 21, "s1_run", ov(0, 0, 1, 0, 0, 0));
    tick_to(b + 10);
    pll_locked = 1'b1;
    tick_to(b + 22);
    drain("s1_drain");

    // 2. Never locks, then 6A restart from FAULT
    do_reset(b);
    push(b + 23, "s2_t1_end", ov(0, 1, 0, 0, 0, 0));
    push(b + 24, "s2_pulse2", ov(1, 1, 0, 0, 1, 0));
    push(b + 27, "s2_pulse2_end", ov(1, 1, 0, 0, 1, 0));
    push(b + 28, "s2_wait2", ov(0, 1, 0, 0, 1, 0));
    push(b + 48, "s2_pulse3", ov(1, 1, 0, 0, 2, 0));
    push(b + 52, "s2_wait3", ov(0, 1, 0, 0, 2, 0));
    push(b + 71, "s2_pre_fault", ov(0, 1, 0, 0, 2, 0));
    push(b + 72, "s2_fault", ov(1, 1, 0, 1, 2, 0));
    for (int k = 1; k <= 5; k++) push(b + 72 + 40 * k, "s2_fault_hold", ov(1, 1, 0, 1, 2, 0));
    tick_to(b + 272);
    c = cyc;
    push(c + 1, "s6a_restart", ov(1, 1, 0, 0, 0, 0));
    push(c + 6, "s6a_repulse", ov(1, 1, 0, 0, 0, 0));
    push(c + 7, "s6a_wait", ov(0, 1, 0, 0, 0, 0));
    restart = 1'b1;
    tick_to(c + 1);
    restart = 1'b0;
    tick_to(c + 2);
    restart = 1'b1;  // re-enters PLL_RST, restarting the pulse count
    tick_to(c + 3);
    restart = 1'b0;
    tick_to(c + 8);
    drain("s2_drain");

    // 3. Late lock after one retry
    do_reset(b);
    push(b + 30, "s3_retry1", ov(0, 1, 0, 0, 1, 0));
    push(b + 35, "s3_stable", ov(0, 1, 0, 0, 1, 0));
    push(b + 42, "s3_before_rel", ov(0, 1, 0, 0, 1, 0));
    push(b + 43, "s3_run", ov(0, 0, 1, 0, 0, 0));
    tick_to(b + 32);
    pll_locked = 1'b1;
    tick_to(b + 44);
    drain("s3_drain");

    // 4. Instability in STABLE, 5. lock loss in RUN, 6B. rst in RUN
    do_reset(b);
    push(b + 19, "s4_back_wait", ov(0, 1, 0, 0, 0, 0));
    push(b + 21, "s4_no_early_rel", ov(0, 1, 0, 0, 0, 0));
    push(b + 27, "s4_before_rel", ov(0, 1, 0, 0, 0, 0));
    push(b + 28, "s4_run", ov(0, 0, 1, 0, 0, 0));
    tick_to(b + 10);
    pll_locked = 1'b1;
    tick_to(b + 16);
    pll_locked = 1'b0;
    tick_to(b + 17);
    pll_locked = 1'b1;
    d = b + 30;
    push(d + 2,  "s5_still_run", ov(0, 0, 1, 0, 0, 0));
    push(d + 3,  "s5_lost", ov(1, 1, 0, 0, 0, 1));
    push(d + 7,  "s5_wait", ov(0, 1, 0, 0, 0, 1));
    push(d + 8,  "s5_stable", ov(0, 1, 0, 0, 0, 1));
    push(d + 15, "s5_before_rel", ov(0, 1, 0, 0, 0, 1));
    push(d + 16, "s5_run_again", ov(0, 0, 1, 0, 0, 1));
    push(d + 20, "s6b_pre_rst", ov(0, 0, 1, 0, 0, 1));
    tick_to(d);
    pll_locked = 1'b0;
    tick_to(d + 1);
    pll_locked = 1'b1;
    tick_to(d + 20);
    do_reset(b);
    tick_to(b + 2);
    drain("s4_drain");

    // 6C. restart and lock drop reach the FSM in the same cycle
    do_reset(b);
    push(b + 21, "s6c_run", ov(0, 0, 1, 0, 0, 0));
    tick_to(b + 10);
    pll_locked = 1'b1;
    c = b + 25;
    push(c + 2,  "s6c_pre", ov(0, 0, 1, 0, 0, 0));
    push(c + 3,  "s6c_restart_wins", RST_V);
    push(c + 4,  "s6c_no_lost", ov(1, 1, 0, 0, 0, 0));
    push(c + 7,  "s6c_wait", ov(0, 1, 0, 0, 0, 0));
    push(c + 16, "s6c_run_again", ov(0, 0, 1, 0, 0, 0));
    tick_to(c);
    pll_locked = 1'b0;
    tick_to(c + 1);
    pll_locked = 1'b1;
    tick_to(c + 2);
    restart = 1'b1;
    tick_to(c + 3);
    restart = 1'b0;
    tick_to(c + 17);
    drain("s6c_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
